// File: rtl/tft_pkg.sv
// Shared definitions for the TFT SPI write link, used by both the transmitter and the receiver.
package tft_pkg;

    localparam int TFT_BYTE_W = 8;

    localparam logic TFT_DC_CMD  = 1'b0;
    localparam logic TFT_DC_DATA = 1'b1;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO. DEPTH must be a power of 2 and at least 2.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tft_spi_rx.sv
// Receive-side SPI endpoint for the TFT write link, oversampled in the clk domain.
// Define TFT_SPI_RX_FIFO_EN for a FIFO_DEPTH-entry output FIFO; otherwise a single output register.
module tft_spi_rx
    import tft_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  global_reset_n,
    input  logic                  spi_clk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs,
    input  logic                  spi_dc,
    output logic [TFT_BYTE_W-1:0] rx_data,
    output logic                  rx_dc,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  overflow,
    output logic                  frame_err,
    input  logic                  clear_err,
    output logic                  active
);

    if (SYNC_STAGES < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("tft_spi_rx: SYNC_STAGES must be >= 2, FIFO_DEPTH a power of 2 >= 2");
    end

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic [SYNC_STAGES-1:0] dc_sync_q, dc_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic                   clk_prev_q;
    logic                   clk_s, mosi_s, dc_s, cs_s, clk_rise;

    rx_state_e             state_q;
    logic [2:0]            cnt_q, cnt_next;
    logic [TFT_BYTE_W-1:0] sr_q;
    logic                  byte_dc_q;
    logic                  push_q;
    logic                  frame_err_q;
    logic                  overflow_q, overflow_d;
    logic                  pop, full;

    // All four inputs share one chain depth so they stay mutually aligned after synchronization.
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
        dc_sync_d   = {dc_sync_q[SYNC_STAGES-2:0], spi_dc};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            clk_sync_q  <= '0;
            mosi_sync_q <= '0;
            dc_sync_q   <= '0;
            cs_sync_q   <= '1;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            mosi_sync_q <= mosi_sync_d;
            dc_sync_q   <= dc_sync_d;
            cs_sync_q   <= cs_sync_d;
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign dc_s     = dc_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign clk_rise = clk_s & ~clk_prev_q;
    assign cnt_next = cnt_q + {2'b00, clk_rise};
    assign active   = ~cs_s;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            sr_q        <= '0;
            byte_dc_q   <= TFT_DC_CMD;
            push_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (clear_err) frame_err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (!cs_s) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (clk_rise) begin
                        sr_q  <= {sr_q[TFT_BYTE_W-2:0], mosi_s};
                        cnt_q <= cnt_next;
                        if (cnt_q == 3'd7) begin
                            push_q    <= 1'b1;
                            byte_dc_q <= dc_s;
                        end
                    end
                    // A clock edge coincident with cs rising is counted before the frame closes.
                    if (cs_s) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                        if (cnt_next != 3'd0) frame_err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pop = rx_valid && rx_ready;

`ifdef TFT_SPI_RX_FIFO_EN
    logic [TFT_BYTE_W:0] fifo_rd;
    logic                fifo_empty;

    sync_fifo #(
        .WIDTH (TFT_BYTE_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (global_reset_n),
        .push      (push_q),
        .push_data ({byte_dc_q, sr_q}),
        .pop       (pop),
        .pop_data  (fifo_rd),
        .full      (full),
        .empty     (fifo_empty)
    );

    assign rx_valid         = !fifo_empty;
    assign {rx_dc, rx_data} = fifo_empty ? '0 : fifo_rd;
`else
    logic                out_valid_q, out_valid_d;
    logic [TFT_BYTE_W:0] out_ent_q, out_ent_d;

    always_comb begin
        out_valid_d = out_valid_q;
        out_ent_d   = out_ent_q;
        if (push_q && (!out_valid_q || pop)) begin
            out_valid_d = 1'b1;
            out_ent_d   = {byte_dc_q, sr_q};
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            out_valid_q <= 1'b0;
            out_ent_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_ent_q   <= out_ent_d;
        end
    end

    assign full     = out_valid_q;
    assign rx_valid = out_valid_q;
    assign rx_dc    = out_ent_q[TFT_BYTE_W];
    assign rx_data  = out_ent_q[TFT_BYTE_W-1:0];
`endif

    // A simultaneous set event wins over clear_err.
    always_comb begin
        overflow_d = overflow_q & ~clear_err;
        if (push_q && full && !pop) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) overflow_q <= 1'b0;
        else                 overflow_q <= overflow_d;
    end

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_tft_spi_rx.sv
// Self-checking bench for tft_spi_rx: a queue model with the documented push latency and
// buffer capacity, checked every cycle, plus literal expectations for each directed scenario.
module tb_tft_spi_rx;
    import tft_pkg::*;

    localparam int SYNC  = 2;
    localparam int DEPTH = 4;
    localparam int HALF  = 4;
`ifdef TFT_SPI_RX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif

    logic       clk = 1'b0;
    logic       global_reset_n = 1'b0;
    logic       spi_clk = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
    logic       rx_ready = 1'b0, clear_err = 1'b0;
    logic [7:0] rx_data;
    logic       rx_dc, rx_valid, overflow, frame_err, active;

    tft_spi_rx #(
        .SYNC_STAGES (SYNC),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .global_reset_n (global_reset_n),
        .spi_clk        (spi_clk),
        .spi_mosi       (spi_mosi),
        .spi_cs         (spi_cs),
        .spi_dc         (spi_dc),
        .rx_data        (rx_data),
        .rx_dc          (rx_dc),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .overflow       (overflow),
        .frame_err      (frame_err),
        .clear_err      (clear_err),
        .active         (active)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned due;
        logic [8:0]  ent;
    } pend_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int          valid_cycles = 0;
    logic        exp_ovf  = 1'b0;
    pend_t       pend_q[$];
    logic [8:0]  mq[$];
    logic [8:0]  pop_log[$];
    logic [8:0]  exp_list[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: a byte enters the buffer SYNC+2 cycles after its last rising spi_clk, if room remains
    // after any pop made at that same clock edge; otherwise it is dropped and overflow is expected.
    always @(negedge clk) begin
        if (global_reset_n) begin
            check("valid_vs_model", rx_valid, mq.size() != 0);
            if (rx_valid && mq.size() != 0) begin
                valid_cycles++;
                check("rx_data", rx_data, mq[0][7:0]);
                check("rx_dc", rx_dc, mq[0][8]);
                if (rx_ready) pop_log.push_back(mq.pop_front());
            end
            check("overflow_model", overflow, exp_ovf);
            while (pend_q.size() != 0 && pend_q[0].due <= cyc + 1) begin
                if (mq.size() < CAP) mq.push_back(pend_q[0].ent);
                else                 exp_ovf = 1'b1;
                void'(pend_q.pop_front());
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b, input logic dc);
        spi_clk  = 1'b0;
        spi_mosi = b;
        spi_dc   = dc;
        step(HALF);
        spi_clk = 1'b1;
        step(HALF);
    endtask

    // Sends bits 7..1, then raises spi_clk for bit 0 and returns right after that edge.
    task automatic send_head(input logic dc, input logic [7:0] b);
        for (int i = 7; i >= 1; i--) spi_bit(b[i], dc);
        spi_clk  = 1'b0;
        spi_mosi = b[0];
        spi_dc   = dc;
        step(HALF);
        spi_clk = 1'b1;
        pend_q.push_back('{due: cyc + SYNC + 2, ent: {dc, b}});
    endtask

    task automatic send_byte(input logic dc, input logic [7:0] b);
        send_head(dc, b);
        step(HALF);
    endtask

    task automatic cs_low();
        spi_cs = 1'b0;
        step(HALF);
    endtask

    task automatic cs_high();
        spi_clk = 1'b0;
        step(HALF);
        spi_cs = 1'b1;
        step(HALF + SYNC + 2);
    endtask

    task automatic pulse_clear();
        clear_err = 1'b1;
        step(1);
        clear_err = 1'b0;
        exp_ovf   = 1'b0;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        step(CAP + 3);
        rx_ready = 1'b0;
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, pop_log.size(), exp_list.size());
        for (int i = 0; i < exp_list.size() && i < pop_log.size(); i++)
            check(name, pop_log[i], exp_list[i]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, rx_data, 8'h00);
        check({tag, "_rx_dc"}, rx_dc, 1'b0);
        check({tag, "_rx_valid"}, rx_valid, 1'b0);
        check({tag, "_overflow"}, overflow, 1'b0);
        check({tag, "_frame_err"}, frame_err, 1'b0);
        check({tag, "_active"}, active, 1'b0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset values
        step(3);
        check_reset_outputs("reset");
        global_reset_n = 1'b1;
        step(2);

        // Single command byte, with latency pinned at SYNC+2 cycles
        cs_low();
        check("active_cs_low", active, 1'b1);
        send_head(TFT_DC_CMD, 8'h2A);
        step(SYNC + 1);
        check("latency_early", rx_valid, 1'b0);
        step(1);
        check("latency_on_time", rx_valid, 1'b1);
        check("single_data", rx_data, 8'h2A);
        check("single_dc", rx_dc, TFT_DC_CMD);
        cs_high();
        check("active_cs_high", active, 1'b0);
        check("single_frame_err", frame_err, 1'b0);
        check("single_overflow", overflow, 1'b0);
        check("single_held", rx_valid, 1'b1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        check("single_popped", rx_valid, 1'b0);

        // Contiguous burst with rx_ready held high
        pop_log.delete();
        valid_cycles = 0;
        rx_ready = 1'b1;
        cs_low();
        send_byte(TFT_DC_CMD, 8'h2C);
        send_byte(TFT_DC_DATA, 8'h12);
        send_byte(TFT_DC_DATA, 8'h34);
        send_byte(TFT_DC_DATA, 8'hAB);
        cs_high();
        rx_ready = 1'b0;
        exp_list = '{9'h02C, 9'h112, 9'h134, 9'h1AB};
        check_log("burst");
        check("burst_one_cycle_each", valid_cycles, 4);
        check("burst_frame_err", frame_err, 1'b0);
        check("burst_overflow", overflow, 1'b0);

        // Partial frame of 5 bits
        cs_low();
        spi_bit(1'b1, TFT_DC_DATA);
        spi_bit(1'b0, TFT_DC_DATA);
        spi_bit(1'b1, TFT_DC_DATA);
        spi_bit(1'b1, TFT_DC_DATA);
        spi_bit(1'b0, TFT_DC_DATA);
        cs_high();
        check("partial_frame_err", frame_err, 1'b1);
        check("partial_no_entry", rx_valid, 1'b0);
        pulse_clear();
        check("partial_cleared", frame_err, 1'b0);

        // Overflow: one byte more than the buffer holds, nothing popped
        pop_log.delete();
        cs_low();
        for (int i = 1; i <= 5; i++) send_byte(TFT_DC_DATA, 8'(i));
        cs_high();
        check("ovf_set", overflow, 1'b1);
        drain();
`ifdef TFT_SPI_RX_FIFO_EN
        exp_list = '{9'h101, 9'h102, 9'h103, 9'h104};
`else
        exp_list = '{9'h101};
`endif
        check_log("ovf_drain");
        pulse_clear();
        check("ovf_cleared", overflow, 1'b0);

        // Buffer full, pop coincides with the push of the next byte
        pop_log.delete();
        cs_low();
        for (int i = 1; i <= CAP; i++) send_byte(TFT_DC_DATA, 8'(i));
        send_head(TFT_DC_DATA, 8'h05);
        step(SYNC + 1);
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        step(HALF - SYNC - 2);
        cs_high();
        check("simul_pop_overflow", overflow, 1'b0);
        drain();
`ifdef TFT_SPI_RX_FIFO_EN
        exp_list = '{9'h101, 9'h102, 9'h103, 9'h104, 9'h105};
`else
        exp_list = '{9'h101, 9'h105};
`endif
        check_log("simul_pop");

        // Reset in the middle of a byte
        cs_low();
        spi_bit(1'b1, TFT_DC_DATA);
        spi_bit(1'b1, TFT_DC_DATA);
        spi_bit(1'b1, TFT_DC_DATA);
        global_reset_n = 1'b0;
        mq.delete();
        pend_q.delete();
        exp_ovf = 1'b0;
        step(1);
        check_reset_outputs("midreset");
        spi_clk = 1'b0;
        spi_cs  = 1'b1;
        step(3);
        global_reset_n = 1'b1;
        step(2);
        pop_log.delete();
        rx_ready = 1'b1;
        cs_low();
        send_byte(TFT_DC_DATA, 8'h55);
        cs_high();
        rx_ready = 1'b0;
        exp_list = '{9'h155};
        check_log("after_reset");
        check("after_reset_frame_err", frame_err, 1'b0);
        check("after_reset_overflow", overflow, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tft_spi_rx.md
# tft_spi_rx

- Receive-side SPI endpoint for the TFT write link, oversampled in the `clk` domain. It deserializes `spi_mosi` and `spi_dc` while `spi_cs` is low into bytes tagged with their D/C bit.
- Bytes are presented on a valid/ready stream, buffered by a small FIFO, with sticky overflow and framing flags.
- It sits on the bench side of the display interface, where it decodes traffic from the TFT SPI transmitter. It also serves as the front end for a future on-chip display-command monitor.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth for all four SPI inputs. Minimum 2.
- `FIFO_DEPTH`, 4: output FIFO entries. Must be a power of 2 and at least 2. Used only when `TFT_SPI_RX_FIFO_EN` is defined.

Ports:
- `clk` in 1: system clock. Must be at least 4× the SPI bit rate.
- `global_reset_n` in 1: asynchronous, active-low reset.
- `spi_clk` in 1: serial clock. Idles low and is gated off while `spi_cs` is high.
- `spi_mosi` in 1: serial data, MSB first.
- `spi_cs` in 1: chip select, active low.
- `spi_dc` in 1: data/command tag. 0 = command, 1 = data.
- `rx_data` out 8: received byte.
- `rx_dc` out 1: D/C tag of `rx_data`.
- `rx_valid` out 1: `rx_data`/`rx_dc` hold a valid entry.
- `rx_ready` in 1: consumer accepts the entry when `rx_valid && rx_ready`.
- `overflow` out 1: sticky. A byte was dropped because the buffer was full.
- `frame_err` out 1: sticky. `spi_cs` rose with a partial byte pending.
- `clear_err` in 1: synchronous clear of `overflow` and `frame_err`.
- `active` out 1: synchronized `spi_cs` is low.

## Operation
- All four SPI inputs pass through identical `SYNC_STAGES`-deep flop chains, which keeps them mutually aligned.
- A rising edge of `spi_clk` is detected from the synchronized value and its one-cycle-delayed copy.
- FSM states:
  - IDLE: synchronized cs is high. Bit counter is 0 and the shift register is ignored. Go to SHIFT on cs low.
  - SHIFT: on each detected rising edge, shift in the synchronized mosi (`{sr[6:0], mosi}`) and increment the 3-bit bit counter.
  - On the edge that completes bit 7, the counter wraps to 0. The completed byte and the synchronized dc at that edge are pushed, and the FSM stays in SHIFT.
  - SHIFT → IDLE on cs high. If the bit counter ≠ 0, set `frame_err` and discard the partial byte.
- Push when the buffer is full: the byte is dropped and `overflow` is set.
  - If a pop happens in the same cycle, the push succeeds and `overflow` is not set.
- Pop occurs on `rx_valid && rx_ready`. `rx_data`/`rx_dc` are stable while `rx_valid` is high and not yet popped.
- `clear_err` clears both sticky flags. A set event in the same cycle wins.
- A cs edge coincident with a `spi_clk` edge: the clock edge is processed first, then the cs transition. A byte completed on that edge is pushed, with no `frame_err`.
- No edges are processed in IDLE. Any glitch on `spi_clk` with cs high is ignored.

## Timing
- Reset values: `rx_data`=0, `rx_dc`=0, `rx_valid`=0, `overflow`=0, `frame_err`=0, `active`=0. FSM is IDLE, counter is 0, FIFO is empty, and all synchronizer flops are reset to their idle levels (cs=1, others 0).
- Reset asserted mid-byte or mid-FIFO discards everything, with no flag set.
- Push latency: `rx_valid` rises `SYNC_STAGES`+2 `clk` cycles after the cycle in which the first sync flop captures `spi_clk` high for bit 7. The breakdown is `SYNC_STAGES` for synchronization, 1 for edge detect plus shift, and 1 for the FIFO write.
- Back-to-back bytes with no gap, with cs held low, are accepted continuously.
- Sustained throughput is one byte per 8 SPI bits, provided the consumer pops at least once per 8 SPI bit periods.
- The consumer may hold `rx_ready` high permanently. Each entry is then presented for exactly one cycle.
- `active` follows cs with `SYNC_STAGES` cycles of latency.
- `frame_err` is set 1 cycle after the synchronized cs rises.

## Configuration
- Macro: `TFT_SPI_RX_FIFO_EN`.
- Defined: a `FIFO_DEPTH`-entry FIFO of 9-bit entries (`{dc, byte}`) with first-word-fall-through output.
- Undefined: a single output register, equivalent to depth 1.
  - Full means `rx_valid` is high.
  - A push while full and not being popped sets `overflow`.
  - `FIFO_DEPTH` is ignored.
  - Push latency is unchanged.

## Structure
- Shared package `tft_pkg`:
  - FSM state enum (IDLE, SHIFT).
  - Byte-width constant (8).
  - D/C encoding constants `TFT_DC_CMD`=0 and `TFT_DC_DATA`=1, shared with the transmitter.
- One sub-module, `sync_fifo`: parameterized width and depth, with first-word-fall-through, push, pop, full and empty. It is instantiated only under `TFT_SPI_RX_FIFO_EN`.
- The synchronizer chains and edge detection stay inline.

## Test plan
- Single command: cs low, send 0x2A with dc=0, cs high → one entry {dc=0, 0x2A}, `rx_valid` at the specified latency, no flags.
- Burst: send 0x2C (dc=0) then 0x12, 0x34, 0xAB (dc=1) contiguously with `rx_ready`=1 → four entries in order with the correct tags, no gaps or drops.
- Partial frame: send 5 bits (10110), then cs high → no entry, `frame_err`=1. Assert `clear_err` → `frame_err`=0.
- Overflow: `rx_ready`=0, send `FIFO_DEPTH`+1 bytes 0x01..0x05 → first four retained, `overflow`=1. Draining yields 0x01..0x04. With the macro undefined, only 0x01 is retained.
- Full plus simultaneous pop: FIFO full, pop in the same cycle as the 5th byte's push → 0x05 accepted, `overflow` stays 0.
- Reset mid-byte: drop `global_reset_n` after 3 bits, release it, then send 0x55 → only 0x55 received, all flags 0, outputs at reset values during reset.
